// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data_ram block.
package data_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int MODE_WRITE_FIRST = 1;
  localparam int MODE_READ_FIRST  = 0;

endpackage

// File: rtl/data_ram_if.sv
// Load/store side bus of the data RAM: request, address/data and status.
interface data_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              clear_req;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, clear_req,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, clear_req,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/data_ram_array.sv
// Bare DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Kept reset-free so it can map onto RAM primitives.
module data_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_ram.sv
// Data RAM controller: range-checked single-port access with registered read
// data and a clear engine that zeroes the array after reset or on request.
//
//   state    | meaning
//   ST_CLEAR | zeroing mem[ptr] each cycle, busy high, requests ignored
//   ST_IDLE  | accepting requests; clear_req restarts the clear
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int WRITE_FIRST = MODE_WRITE_FIRST
) (
  input  logic       clk,
  input  logic       reset,
  data_ram_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam bit                WF_EN     = (WRITE_FIRST == MODE_WRITE_FIRST);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              in_range;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              err_q;

  assign in_range = ({1'b0, bus.addr} < DEPTH_EXT);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.addr;
    mem_wdata = bus.wdata;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = '0;
        if (ptr == PTR_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        // clear_req wins over a simultaneous request, which is dropped
        if (bus.clear_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end else if (bus.req) begin
          accept = 1'b1;
          mem_we = bus.we && in_range;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // mem_rdata is sampled before the write lands, so it is the old contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= accept;
      err_q <= accept && !in_range;
      if (accept) begin
        if (!in_range) begin
          rdata_q <= '0;
        end else if (bus.we && WF_EN) begin
          rdata_q <= bus.wdata;
        end else begin
          rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state == ST_CLEAR);

  data_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: three configurations driven by one stimulus stream,
// checked every cycle against a behavioural model plus literal spot checks.
module tb_data_ram;

  localparam int NI = 3;
  localparam int DEP [NI] = '{64, 64, 48};
  localparam bit WFM [NI] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic       clear_req = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] wdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_ram_if #(.DATA_W(8), .ADDR_W(6)) ifa ();
  data_ram_if #(.DATA_W(8), .ADDR_W(6)) ifb ();
  data_ram_if #(.DATA_W(8), .ADDR_W(6)) ifc ();

  assign ifa.req = req;  assign ifa.we = we;  assign ifa.addr = addr;
  assign ifa.wdata = wdata;  assign ifa.clear_req = clear_req;
  assign ifb.req = req;  assign ifb.we = we;  assign ifb.addr = addr;
  assign ifb.wdata = wdata;  assign ifb.clear_req = clear_req;
  assign ifc.req = req;  assign ifc.we = we;  assign ifc.addr = addr;
  assign ifc.wdata = wdata;  assign ifc.clear_req = clear_req;

  data_ram #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .WRITE_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  data_ram #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .WRITE_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));
  data_ram #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .WRITE_FIRST(1)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc));

  logic [7:0] o_rdata [NI];
  logic       o_ack [NI];
  logic       o_err [NI];
  logic       o_busy [NI];

  assign o_rdata[0] = ifa.rdata;  assign o_ack[0] = ifa.ack;
  assign o_err[0]   = ifa.err;    assign o_busy[0] = ifa.busy;
  assign o_rdata[1] = ifb.rdata;  assign o_ack[1] = ifb.ack;
  assign o_err[1]   = ifb.err;    assign o_busy[1] = ifb.busy;
  assign o_rdata[2] = ifc.rdata;  assign o_ack[2] = ifc.ack;
  assign o_err[2]   = ifc.err;    assign o_busy[2] = ifc.busy;

  // Model: words left to clear, memory image, and last access result
  int         clr_left [NI];
  logic [7:0] mm [NI][64];
  logic [7:0] m_rdata [NI];
  logic       m_ack [NI];
  logic       m_err [NI];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        clr_left[k] <= DEP[k];
        m_ack[k]    <= 1'b0;
        m_err[k]    <= 1'b0;
        m_rdata[k]  <= 8'h00;
      end else if (clr_left[k] > 0) begin
        mm[k][DEP[k] - clr_left[k]] <= 8'h00;
        clr_left[k] <= clr_left[k] - 1;
        m_ack[k]    <= 1'b0;
        m_err[k]    <= 1'b0;
      end else if (clear_req) begin
        clr_left[k] <= DEP[k];
        m_ack[k]    <= 1'b0;
        m_err[k]    <= 1'b0;
      end else if (req) begin
        m_ack[k] <= 1'b1;
        if (int'(addr) >= DEP[k]) begin
          m_err[k]   <= 1'b1;
          m_rdata[k] <= 8'h00;
        end else begin
          m_err[k] <= 1'b0;
          if (we) begin
            mm[k][addr] <= wdata;
            m_rdata[k]  <= WFM[k] ? wdata : mm[k][addr];
          end else begin
            m_rdata[k] <= mm[k][addr];
          end
        end
      end else begin
        m_ack[k] <= 1'b0;
        m_err[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[dut %0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("model_ack",   k, 32'(o_ack[k]),   32'(m_ack[k]));
        chk("model_err",   k, 32'(o_err[k]),   32'(m_err[k]));
        chk("model_rdata", k, 32'(o_rdata[k]), 32'(m_rdata[k]));
        chk("model_busy",  k, 32'(o_busy[k]),  32'(clr_left[k] > 0));
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [5:0] a,
                       input logic [7:0] d, input logic c);
    req = r; we = w; addr = a; wdata = d; clear_req = c;
    @(negedge clk);
  endtask

  int bcnt [NI];
  int ack_while_busy;

  // Count busy samples per instance until all are idle, with a cycle bound
  task automatic count_busy();
    bit any;
    bit done;
    done = 1'b0;
    ack_while_busy = 0;
    for (int k = 0; k < NI; k++) bcnt[k] = 0;
    for (int i = 0; i < 300; i++) begin
      any = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (o_busy[k] === 1'b1) begin
          bcnt[k]++;
          any = 1'b1;
          if (o_ack[k] !== 1'b0) ack_while_busy++;
        end
      end
      if (!any) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("busy_bound", 0, 32'(done), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy",  k, 32'(o_busy[k]),  32'd1);
      chk("rst_ack",   k, 32'(o_ack[k]),   32'd0);
      chk("rst_rdata", k, 32'(o_rdata[k]), 32'd0);
    end

    reset = 1'b0;
    count_busy();
    chk("init_clear_len", 0, 32'(bcnt[0]), 32'd64);
    chk("init_clear_len", 1, 32'(bcnt[1]), 32'd64);
    chk("init_clear_len", 2, 32'(bcnt[2]), 32'd48);

    drive(1, 0, 6'd0, 8'h00, 0);
    drive(1, 0, 6'd31, 8'h00, 0);
    drive(1, 0, 6'd63, 8'h00, 0);
    chk("rd63_ack",   0, 32'(o_ack[0]),   32'd1);
    chk("rd63_err",   0, 32'(o_err[0]),   32'd0);
    chk("rd63_rdata", 0, 32'(o_rdata[0]), 32'h00);
    chk("rd63_err",   2, 32'(o_err[2]),   32'd1);

    drive(1, 1, 6'd5, 8'hA5, 0);
    chk("wr5_rdata_wf", 0, 32'(o_rdata[0]), 32'hA5);
    chk("wr5_rdata_rf", 1, 32'(o_rdata[1]), 32'h00);
    chk("wr5_ack",      1, 32'(o_ack[1]),   32'd1);
    drive(1, 0, 6'd5, 8'h00, 0);
    chk("rd5_ack",   0, 32'(o_ack[0]),   32'd1);
    chk("rd5_rdata", 0, 32'(o_rdata[0]), 32'hA5);
    chk("rd5_rdata", 1, 32'(o_rdata[1]), 32'hA5);

    drive(1, 1, 6'd50, 8'h3C, 0);
    chk("wr50_ack",   2, 32'(o_ack[2]),   32'd1);
    chk("wr50_err",   2, 32'(o_err[2]),   32'd1);
    chk("wr50_rdata", 2, 32'(o_rdata[2]), 32'h00);
    chk("wr50_rdata", 0, 32'(o_rdata[0]), 32'h3C);
    drive(0, 0, 6'd0, 8'h00, 0);
    chk("idle_ack",  0, 32'(o_ack[0]),   32'd0);
    chk("hold_rdata", 0, 32'(o_rdata[0]), 32'h3C);
    drive(1, 0, 6'd50, 8'h00, 0);
    chk("rd50_err",   2, 32'(o_err[2]),   32'd1);
    chk("rd50_rdata", 2, 32'(o_rdata[2]), 32'h00);

    drive(1, 1, 6'd47, 8'h77, 0);
    chk("wr47_err", 2, 32'(o_err[2]), 32'd0);
    drive(1, 0, 6'd47, 8'h00, 0);
    chk("rd47_rdata", 2, 32'(o_rdata[2]), 32'h77);
    drive(1, 1, 6'd48, 8'h99, 0);
    chk("wr48_err", 2, 32'(o_err[2]), 32'd1);

    for (int i = 0; i < 4; i++) drive(1, 1, 6'(i), 8'(8'h11 * (i + 1)), 0);
    drive(1, 0, 6'd3, 8'h00, 0);
    chk("rd3_rdata", 0, 32'(o_rdata[0]), 32'h44);

    drive(1, 0, 6'd1, 8'h00, 1);
    chk("clr_req_drop_ack", 0, 32'(o_ack[0]),  32'd0);
    chk("clr_busy",         0, 32'(o_busy[0]), 32'd1);
    req = 1'b0; clear_req = 1'b0;
    count_busy();
    chk("clr_len", 0, 32'(bcnt[0]), 32'd64);
    chk("clr_len", 2, 32'(bcnt[2]), 32'd48);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 6'(i), 8'h00, 0);
      chk("clr_rd_rdata", 0, 32'(o_rdata[0]), 32'h00);
    end

    drive(0, 0, 6'd0, 8'h00, 1);
    clear_req = 1'b0;
    for (int i = 0; i < 20; i++) drive(1, 1, 6'd9, 8'hEE, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midclr_rst_busy", 0, 32'(o_busy[0]), 32'd1);
    req = 1'b1; we = 1'b0; addr = 6'd5;
    reset = 1'b0;
    count_busy();
    chk("reclear_len",    0, 32'(bcnt[0]), 32'd64);
    chk("ack_while_busy", 0, 32'(ack_while_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_busy_ack",   0, 32'(o_ack[0]),   32'd1);
      chk("post_busy_rdata", 0, 32'(o_rdata[0]), 32'h00);
    end
    drive(0, 0, 6'd0, 8'h00, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
